// File: rtl/seqchk_pkg.sv
// Shared definitions for the sequence-check path: debounce FSM state encoding
// and default timing constants reused by the window checker and its bench.
package seqchk_pkg;

    typedef enum logic [1:0] {
        S_LOW    = 2'b00,
        S_CHK_HI = 2'b01,
        S_HIGH   = 2'b11,
        S_CHK_LO = 2'b10
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STABLE_CYC  = 4;
    localparam int DEF_GCNT_W      = 8;

endpackage

// File: rtl/sig_debounce_sync_ff.sv
// Reset-to-0 multi-flop synchroniser for an asynchronous single-bit input.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the raw input through the chain; the oldest stage is the synced output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_r <= {STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/sig_debounce.sv
// Input conditioner: synchronises raw_in and only changes sig_out after
// STABLE_CYC consecutive equal synced samples; reports edges and rejected glitches.
module sig_debounce
    import seqchk_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE_CYC  = DEF_STABLE_CYC,
    parameter int GCNT_W      = DEF_GCNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              raw_in,
    input  logic              glitch_clr,
    output logic              sig_out,
    output logic              rise,
    output logic              fall,
    output logic [GCNT_W-1:0] glitch_cnt
);

    localparam int                CNT_W     = $clog2(STABLE_CYC);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYC - 1);
    localparam logic [GCNT_W-1:0] GCNT_ZERO = {GCNT_W{1'b0}};
    localparam logic [GCNT_W-1:0] GCNT_ONE  = GCNT_W'(1);
    localparam logic [GCNT_W-1:0] GCNT_MAX  = {GCNT_W{1'b1}};

    logic              syn_s;
    logic              abort_s;
    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              sig_r;
    logic              rise_r;
    logic              fall_r;
    logic [GCNT_W-1:0] gcnt_r;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_in),
        .q     (syn_s)
    );

    // A check is aborted as a glitch only when the filter is enabled and the
    // synced level falls back to the committed level before the count completes.
    always_comb begin
        abort_s = 1'b0;
        if (en) begin
            case (state_r)
                S_CHK_HI: abort_s = ~syn_s;
                S_CHK_LO: abort_s = syn_s;
                default:  abort_s = 1'b0;
            endcase
        end else begin
            abort_s = 1'b0;
        end
    end

    // Debounce FSM with stability counter and registered level/edge outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_LOW;
            cnt_r   <= CNT_ZERO;
            sig_r   <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            case (state_r)
                S_LOW: begin
                    if (en && syn_s) begin
                        state_r <= S_CHK_HI;
                        cnt_r   <= CNT_ONE;
                    end
                end
                S_CHK_HI: begin
                    if (!en || !syn_s) begin
                        state_r <= S_LOW;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= S_HIGH;
                        sig_r   <= 1'b1;
                        rise_r  <= 1'b1;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (en && !syn_s) begin
                        state_r <= S_CHK_LO;
                        cnt_r   <= CNT_ONE;
                    end
                end
                S_CHK_LO: begin
                    if (!en || syn_s) begin
                        state_r <= S_HIGH;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= S_LOW;
                        sig_r   <= 1'b0;
                        fall_r  <= 1'b1;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= S_LOW;
                    cnt_r   <= CNT_ZERO;
                    sig_r   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating glitch counter; a clear request overrides a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gcnt_r <= GCNT_ZERO;
        end else if (glitch_clr) begin
            gcnt_r <= GCNT_ZERO;
        end else if (abort_s && (gcnt_r != GCNT_MAX)) begin
            gcnt_r <= gcnt_r + GCNT_ONE;
        end else begin
            gcnt_r <= gcnt_r;
        end
    end

    assign sig_out    = sig_r;
    assign rise       = rise_r;
    assign fall       = fall_r;
    assign glitch_cnt = gcnt_r;

endmodule

// File: tb/tb_sig_debounce.sv
// Directed scenarios plus randomized traffic for sig_debounce, checked against
// a run-length reference model of the debounce rules.
module tb_sig_debounce;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int GMAX   = 255;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       raw_in;
    logic       glitch_clr;
    logic       sig_out;
    logic       rise;
    logic       fall;
    logic [7:0] glitch_cnt;

    int n_vec;
    int n_err;

    // reference model state
    bit m_hist [SYNC];
    bit m_out;
    bit m_rise;
    bit m_fall;
    int m_run;
    int m_gcnt;

    sig_debounce dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .raw_in     (raw_in),
        .glitch_clr (glitch_clr),
        .sig_out    (sig_out),
        .rise       (rise),
        .fall       (fall),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge: advance the model with the inputs seen at the edge, then settle.
    task automatic tick();
        bit syn;
        bit inc;
        @(posedge clk);
        syn = m_hist[SYNC-1];
        inc = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
            m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_gcnt = 0;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_run == 0) begin
                if (en && (syn != m_out)) m_run = 1;
            end else if (!en) begin
                m_run = 0;
            end else if (syn == m_out) begin
                m_run = 0;
                inc = 1'b1;
            end else if (m_run + 1 == STABLE) begin
                m_out = syn; m_rise = syn; m_fall = !syn; m_run = 0;
            end else begin
                m_run++;
            end
            if (glitch_clr) m_gcnt = 0;
            else if (inc && m_gcnt < GMAX) m_gcnt++;
            for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = raw_in;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; raw_in = 1'b0; glitch_clr = 1'b0;
        tick(); tick();
        n_vec++;
        if (sig_out !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || glitch_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset: got sig=%b rise=%b fall=%b gcnt=%0d, expected all 0", sig_out, rise, fall, glitch_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        raw_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_vec++;
            if (sig_out !== (k >= 6) || rise !== (k == 6) || fall !== 1'b0) begin
                n_err++;
                $display("FAIL latency edge %0d: got sig=%b rise=%b fall=%b, expected sig=%b rise=%b fall=0", k, sig_out, rise, fall, k >= 6, k == 6);
            end
        end
    endtask

    task automatic test_fall();
        raw_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_vec++;
            if (sig_out !== (k < 6) || fall !== (k == 6) || rise !== 1'b0 || glitch_cnt !== 8'd0) begin
                n_err++;
                $display("FAIL fall edge %0d: got sig=%b fall=%b rise=%b gcnt=%0d, expected sig=%b fall=%b rise=0 gcnt=0", k, sig_out, fall, rise, glitch_cnt, k < 6, k == 6);
            end
        end
    endtask

    task automatic test_glitch_sat();
        bit any_rise;
        int exp_g;
        for (int i = 0; i < 300; i++) begin
            any_rise = 1'b0;
            raw_in = 1'b1;
            for (int k = 0; k < 3; k++) begin tick(); any_rise |= rise; end
            raw_in = 1'b0;
            for (int k = 0; k < 3; k++) begin tick(); any_rise |= rise; end
            exp_g = (i + 1 > GMAX) ? GMAX : i + 1;
            n_vec++;
            if (sig_out !== 1'b0 || any_rise || glitch_cnt !== exp_g[7:0]) begin
                n_err++;
                $display("FAIL glitch rep %0d: got sig=%b rise_seen=%b gcnt=%0d, expected sig=0 rise_seen=0 gcnt=%0d", i, sig_out, any_rise, glitch_cnt, exp_g);
            end
        end
    endtask

    task automatic test_enable();
        int edges;
        bit seen;
        raw_in = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        en = 1'b0;
        tick();
        n_vec++;
        if (sig_out !== 1'b0 || rise !== 1'b0 || glitch_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL enable_abort: got sig=%b rise=%b gcnt=%0d, expected sig=0 rise=0 gcnt=255", sig_out, rise, glitch_cnt);
        end
        en = 1'b1;
        edges = 0;
        seen = 1'b0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            tick();
            if (rise === 1'b1) begin seen = 1'b1; edges = k; end
        end
        n_vec++;
        if (!seen || edges != STABLE || sig_out !== 1'b1 || glitch_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL enable_recheck: got rise after %0d edges (seen=%b) sig=%b gcnt=%0d, expected 4 edges sig=1 gcnt=255", edges, seen, sig_out, glitch_cnt);
        end
    endtask

    task automatic test_reset_mid();
        raw_in = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        n_vec++;
        if (sig_out !== 1'b1 || fall !== 1'b0) begin
            n_err++;
            $display("FAIL pre_reset_chk_lo: got sig=%b fall=%b, expected sig=1 fall=0", sig_out, fall);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_vec++;
        if (sig_out !== 1'b0 || fall !== 1'b0 || rise !== 1'b0 || glitch_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid: got sig=%b fall=%b rise=%b gcnt=%0d, expected all 0", sig_out, fall, rise, glitch_cnt);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            n_vec++;
            if (sig_out !== 1'b0 || fall !== 1'b0 || glitch_cnt !== 8'd0) begin
                n_err++;
                $display("FAIL post_reset %0d: got sig=%b fall=%b gcnt=%0d, expected 0 0 0", k, sig_out, fall, glitch_cnt);
            end
        end
    endtask

    task automatic test_clr_collision();
        for (int i = 0; i < 7; i++) begin
            raw_in = 1'b1;
            for (int k = 0; k < 3; k++) tick();
            raw_in = 1'b0;
            for (int k = 0; k < 3; k++) tick();
        end
        raw_in = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        raw_in = 1'b0;
        tick(); tick();
        n_vec++;
        if (glitch_cnt !== 8'd7) begin
            n_err++;
            $display("FAIL clr_pre: got gcnt=%0d, expected 7", glitch_cnt);
        end
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        n_vec++;
        if (glitch_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL clr_collision: got gcnt=%0d, expected 0", glitch_cnt);
        end
        tick();
        n_vec++;
        if (glitch_cnt !== 8'd0 || sig_out !== 1'b0) begin
            n_err++;
            $display("FAIL clr_hold: got gcnt=%0d sig=%b, expected 0 0", glitch_cnt, sig_out);
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                raw_in = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
            en = ($urandom_range(0, 15) != 0);
            glitch_clr = ($urandom_range(0, 63) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
            n_vec++;
            if (sig_out !== m_out || rise !== m_rise || fall !== m_fall || glitch_cnt !== m_gcnt[7:0] || (rise && fall)) begin
                n_err++;
                $display("FAIL random cycle %0d: got sig=%b rise=%b fall=%b gcnt=%0d, expected sig=%b rise=%b fall=%b gcnt=%0d", c, sig_out, rise, fall, glitch_cnt, m_out, m_rise, m_fall, m_gcnt);
            end
        end
        rst_n = 1'b1; en = 1'b1; glitch_clr = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
        m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_gcnt = 0;
        test_reset();
        test_latency();
        test_fall();
        test_glitch_sat();
        test_enable();
        test_reset_mid();
        test_clr_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
